// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse trainer round sequencer.
// Holds the FSM state set, result codes and the letter-length clamp.
package morse_pkg;

  localparam int MAX_SYMS = 5;
  localparam int TICKS_5S = 50;
  localparam int LEN_W    = 3;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    WAIT_SYM,
    RESULT,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    PASS,
    FAIL,
    TIMEOUT
  } res_t;

  // A zero-length letter still needs one symbol; long ones are cut to the pattern width.
  function automatic logic [LEN_W-1:0] clamp_len(
    input logic [LEN_W-1:0] len,
    input int               max_syms
  );
    if (len == '0)
      return LEN_W'(1);
    if (int'(len) > max_syms)
      return LEN_W'(max_syms);
    return len;
  endfunction

endpackage

// File: rtl/morse_tick_timer.sv
// Clear/enable tick counter that saturates one short of its limit.
// o_expire flags the enabled tick that would reach the limit.
module morse_tick_timer #(
  parameter int LIMIT = 50,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count,
  output logic             o_expire
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] r_count;

  // Count enabled ticks, holding at LAST so the value never wraps.
  always_ff @(posedge clk) begin
    if (rst || i_clr)
      r_count <= '0;
    else if (i_en && (r_count != LAST))
      r_count <= r_count + CNT_W'(1);
  end

  assign o_count  = r_count;
  assign o_expire = i_en && (r_count == LAST);

endmodule

// File: rtl/morse_round_ctrl.sv
// Round sequencer for the Morse trainer: fetch letter, collect symbols,
// enforce the per-letter timeout, report the outcome and keep the score.
module morse_round_ctrl #(
  parameter int TIMEOUT_TICKS = morse_pkg::TICKS_5S,
  parameter int NUM_ROUNDS    = 8,
  parameter int ADDR_W        = 5,
  parameter int MAX_SYMS      = morse_pkg::MAX_SYMS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                tick_100ms,
  input  logic                sym_valid,
  input  logic                sym_is_dash,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [MAX_SYMS-1:0] rom_pattern,
  input  logic [2:0]          rom_len,
  output logic                busy,
  output logic [5:0]          timer_count,
  output logic                round_pass,
  output logic                round_fail,
  output logic                round_timeout,
  output logic [4:0]          score,
  output logic                game_done
);

  import morse_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ROUND = ADDR_W'(NUM_ROUNDS - 1);
  localparam logic [4:0]        SCORE_MAX  = 5'd31;

  state_t               r_state;
  res_t                 r_res;
  logic [ADDR_W-1:0]    r_round_idx;
  logic [ADDR_W-1:0]    r_rom_addr;
  logic [4:0]           r_score;
  logic [MAX_SYMS-1:0]  r_pattern;
  logic [LEN_W-1:0]     r_len;
  logic [LEN_W-1:0]     r_sym_idx;
  logic                 r_pass;
  logic                 r_fail;
  logic                 r_timeout;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_clr;
  logic                 w_tick_en;
  logic                 w_expire;
  logic                 w_end;
  logic                 w_adv;
  res_t                 w_res;

  assign w_clr     = (r_state == LOAD);
  assign w_tick_en = tick_100ms && (r_state == WAIT_SYM);

  morse_tick_timer #(
    .LIMIT (TIMEOUT_TICKS),
    .CNT_W (6)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_clr),
    .i_en     (w_tick_en),
    .o_count  (timer_count),
    .o_expire (w_expire)
  );

  // Judge the current cycle: the symbol decides first, expiry only if it did not.
  always_comb begin
    w_end = 1'b0;
    w_adv = 1'b0;
    w_res = PASS;
    if (r_state == WAIT_SYM) begin
      if (sym_valid && (sym_is_dash != r_pattern[r_sym_idx])) begin
        w_end = 1'b1;
        w_res = FAIL;
      end else if (sym_valid && ((r_sym_idx + LEN_W'(1)) == r_len)) begin
        w_end = 1'b1;
        w_res = PASS;
      end else if (w_expire) begin
        w_end = 1'b1;
        w_res = TIMEOUT;
      end else if (sym_valid) begin
        w_adv = 1'b1;
      end
    end
  end

  // Game sequencer with registered outputs; result pulses live only in RESULT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_res       <= PASS;
      r_round_idx <= '0;
      r_rom_addr  <= '0;
      r_score     <= '0;
      r_pattern   <= '0;
      r_len       <= '0;
      r_sym_idx   <= '0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
      r_timeout   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_pass    <= 1'b0;
      r_fail    <= 1'b0;
      r_timeout <= 1'b0;
      unique case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state     <= FETCH;
            r_round_idx <= '0;
            r_rom_addr  <= '0;
            r_score     <= '0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
          end
        end
        FETCH: begin
          r_state <= LOAD;
        end
        LOAD: begin
          r_pattern <= rom_pattern;
          r_len     <= clamp_len(rom_len, MAX_SYMS);
          r_sym_idx <= '0;
          r_state   <= WAIT_SYM;
        end
        WAIT_SYM: begin
          if (w_end) begin
            r_state   <= RESULT;
            r_res     <= w_res;
            r_pass    <= (w_res == PASS);
            r_fail    <= (w_res == FAIL);
            r_timeout <= (w_res == TIMEOUT);
          end else if (w_adv) begin
            r_sym_idx <= r_sym_idx + LEN_W'(1);
          end
        end
        RESULT: begin
          if ((r_res == PASS) && (r_score != SCORE_MAX))
            r_score <= r_score + 5'd1;
          r_round_idx <= r_round_idx + ADDR_W'(1);
          if (r_round_idx == LAST_ROUND) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state    <= FETCH;
            r_rom_addr <= r_round_idx + ADDR_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign rom_addr      = r_rom_addr;
  assign busy          = r_busy;
  assign round_pass    = r_pass;
  assign round_fail    = r_fail;
  assign round_timeout = r_timeout;
  assign score         = r_score;
  assign game_done     = r_done;

endmodule

// File: doc/morse_round_ctrl.md
Name: morse_round_ctrl

Overview:
Game sequencer for the Morse trainer. It runs NUM_ROUNDS rounds. Each round it fetches the expected letter pattern from the pattern ROM, collects dot/dash symbols from the symbol classifier, and enforces a per-letter timeout counted in 100 ms ticks. It reports pass/fail/timeout per round and keeps a running score. It sits between the tick-prescaler chain, the symbol classifier and the display/score logic.

Parameters:
TIMEOUT_TICKS, 50, number of tick_100ms pulses allowed per letter (50 = 5 s)
NUM_ROUNDS, 8, rounds per game (1..31)
ADDR_W, 5, pattern ROM address width
MAX_SYMS, 5, maximum symbols per letter (pattern width)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start  in  1  level or pulse; begins a game from IDLE or DONE
tick_100ms  in  1  single-cycle pulse every 100 ms
sym_valid  in  1  single-cycle pulse: one classified symbol
sym_is_dash  in  1  qualifies sym_valid: 1 = dash, 0 = dot
rom_addr  out  ADDR_W  pattern ROM address (= round index)
rom_pattern  in  MAX_SYMS  bit i = symbol i, 1 = dash; valid 1 cycle after rom_addr
rom_len  in  3  symbol count of the letter
busy  out  1  high in every state except IDLE/DONE
timer_count  out  6  ticks elapsed in the current letter
round_pass  out  1  1-cycle pulse, letter correct
round_fail  out  1  1-cycle pulse, wrong symbol
round_timeout  out  1  1-cycle pulse, letter timed out
score  out  5  passed rounds this game
game_done  out  1  level, high in DONE

Behaviour:
- Reset: state IDLE; rom_addr=0, timer_count=0, score=0; all pulses 0; busy=0; game_done=0. Reset mid-round aborts immediately; no result pulse is emitted.
- IDLE: on start -> FETCH; round_idx=0, score=0.
- FETCH (1 cycle): drive rom_addr=round_idx -> LOAD.
- LOAD (1 cycle): capture rom_pattern/rom_len.
  - rom_len=0 -> treat as 1.
  - rom_len>MAX_SYMS -> treat as MAX_SYMS.
  - Clear sym_idx and timer_count -> WAIT_SYM.
- WAIT_SYM:
  - Each tick_100ms increments timer_count.
  - On sym_valid: compare sym_is_dash with pattern[sym_idx].
    - Mismatch -> RESULT(fail).
    - Match and sym_idx+1==len -> RESULT(pass).
    - Otherwise sym_idx++.
  - Timeout: tick_100ms while timer_count==TIMEOUT_TICKS-1 -> RESULT(timeout). The 50th tick expires the letter.
  - Simultaneous sym_valid and expiring tick: the symbol is evaluated first. If it completes or fails the letter, that result wins; otherwise timeout.
  - sym_valid outside WAIT_SYM is ignored.
- RESULT (1 cycle): assert exactly one of round_pass/round_fail/round_timeout.
  - score+1 on pass; score saturates at 31.
  - round_idx++; if round_idx==NUM_ROUNDS-1 -> DONE, else FETCH.
- DONE: game_done=1; score held; timer_count held. start -> FETCH with score=0, round_idx=0.
- start is ignored while busy.
- Latency: start to first rom_addr valid = 1 cycle. Last accepted symbol to result pulse = 1 cycle.
- timer_count stops at TIMEOUT_TICKS-1 and never wraps.

Decomposition:
- Package morse_pkg:
  - state enum: IDLE, FETCH, LOAD, WAIT_SYM, RESULT, DONE
  - result code enum: PASS, FAIL, TIMEOUT
  - constants: MAX_SYMS, TICKS_5S=50, LEN_W=3
- One sub-module, morse_tick_timer: a clear/enable tick counter with expiry output, reused by the other timeout users.

Test Plan:
- Game start: rst 1 cycle, then start. ROM round0 pattern=5'b00010, len=2 (A). Drive dot then dash -> round_pass 1 cycle after the dash; score=1; rom_addr=1 next FETCH.
- Wrong symbol: round pattern len=3 all dots (S). Drive dot, dash -> round_fail 1 cycle after the dash; score unchanged; third symbol ignored.
- Timeout: enter WAIT_SYM and send 50 ticks with no symbols -> round_timeout on the cycle after the 50th tick; timer_count=49 before the pulse.
- Simultaneous final symbol and expiring tick: last correct symbol on the same cycle as the 50th tick -> round_pass, not round_timeout.
- Full game: NUM_ROUNDS=8, all correct -> score=8, game_done=1 after the 8th RESULT. start in DONE -> score=0, rom_addr=0.
- Mid-round reset: rst asserted during WAIT_SYM with timer_count=20 -> next cycle IDLE, all outputs at reset values, no result pulse.
